// File: rtl/instr_fetch.sv
// Instruction fetch: one outstanding memory read feeding a small
// in-order fetch queue, with redirect flush and in-flight drop.
module instr_fetch #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_index,
  input  logic        pc_valid,
  output logic        pc_ready,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        redirect,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DROP
  } state_e;

  state_e        state_q;
  logic [31:0]   idx_q;
  logic          mem_req_q;
  logic [31:0]   mem_addr_q;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [31:0]   data_q [DEPTH];
  logic [31:0]   pc_q   [DEPTH];

  logic          accept;
  logic          push;
  logic          pop;

  assign pc_ready = (state_q == IDLE)
                  & (count_q < CW'(DEPTH))
                  & ~redirect;

  assign accept = pc_valid & pc_ready;

  // A response is only kept when it answers a live request.
  assign push = reset & (state_q == REQ)
              & mem_ack & ~redirect;

  assign inst_valid = (count_q != '0);
  assign pop = inst_valid & inst_ready & ~redirect;

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;

  assign inst_data = inst_valid ? data_q[rd_ptr_q] : '0;
  assign inst_pc   = inst_valid ? pc_q[rd_ptr_q]   : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            idx_q      <= pc_index;
            mem_addr_q <= {pc_index[29:0], 2'b00};
            mem_req_q  <= 1'b1;
            state_q    <= REQ;
          end
        end
        REQ: begin
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            state_q   <= IDLE;
          end else if (redirect) begin
            state_q <= DROP;
          end
        end
        DROP: begin
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: begin
          mem_req_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (redirect) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; the read side is gated by inst_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr_q] <= mem_rdata;
      pc_q[wr_ptr_q]   <= idx_q;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: vector table for the basic
// fetch/flush flow plus sequences for queue, drop and reset cases.
module tb_instr_fetch;

  logic        clk;
  logic        reset;
  logic [31:0] pc_index;
  logic        pc_valid;
  logic        pc_ready;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        redirect;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  int checks = 0;
  int errors = 0;

  instr_fetch #(.DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .pc_index  (pc_index),
    .pc_valid  (pc_valid),
    .pc_ready  (pc_ready),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .redirect  (redirect),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .inst_data (inst_data),
    .inst_pc   (inst_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pv;
    logic [31:0] idx;
    logic        ack;
    logic [31:0] rd;
    logic        rdr;
    logic        ir;
    logic        e_pr;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_pc;
    logic [31:0] e_data;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input logic [31:0] idx,
                          input logic [31:0] data,
                          input logic pop_at_ack);
    int n;
    logic [31:0] ea;
    n = 0;
    ea = {idx[29:0], 2'b00};
    pc_valid = 1'b1;
    pc_index = idx;
    #1;
    while (!pc_ready && n < 20) begin
      cyc();
      n++;
    end
    chk($sformatf("accept_%0d", idx), 32'(n < 20), 32'd1);
    cyc();
    pc_valid = 1'b0;
    chk($sformatf("req_hi_%0d", idx), 32'(mem_req), 32'd1);
    chk($sformatf("addr_%0d", idx), mem_addr, ea);
    cyc();
    mem_ack   = 1'b1;
    mem_rdata = data;
    if (pop_at_ack) inst_ready = 1'b1;
    cyc();
    mem_ack = 1'b0;
    if (pop_at_ack) inst_ready = 1'b0;
    chk($sformatf("req_lo_%0d", idx), 32'(mem_req), 32'd0);
  endtask

  task automatic chk_head(input string nm,
                          input logic [31:0] pc,
                          input logic [31:0] data);
    chk({nm, "_iv"}, 32'(inst_valid), 32'd1);
    chk({nm, "_pc"}, inst_pc, pc);
    chk({nm, "_data"}, inst_data, data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b1, 32'd5, 1'b0, 32'd0, 1'b0, 1'b0,
               1'b1, 1'b0, 32'h0, 1'b0, 32'd0, 32'h0};
    tbl[1] = '{1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0,
               1'b0, 1'b1, 32'h14, 1'b0, 32'd0, 32'h0};
    tbl[2] = '{1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0,
               1'b0, 1'b1, 32'h14, 1'b0, 32'd0, 32'h0};
    tbl[3] = '{1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0,
               1'b0, 1'b1, 32'h14, 1'b0, 32'd0, 32'h0};
    tbl[4] = '{1'b0, 32'd0, 1'b1, 32'h8C220004, 1'b0, 1'b0,
               1'b0, 1'b1, 32'h14, 1'b0, 32'd0, 32'h0};
    tbl[5] = '{1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1,
               1'b1, 1'b0, 32'h0, 1'b1, 32'd5, 32'h8C220004};
    tbl[6] = '{1'b1, 32'd7, 1'b0, 32'd0, 1'b0, 1'b0,
               1'b1, 1'b0, 32'h0, 1'b0, 32'd0, 32'h0};
    tbl[7] = '{1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0,
               1'b0, 1'b1, 32'h1C, 1'b0, 32'd0, 32'h0};
    tbl[8] = '{1'b0, 32'd0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0,
               1'b0, 1'b1, 32'h1C, 1'b0, 32'd0, 32'h0};
    tbl[9] = '{1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0,
               1'b1, 1'b0, 32'h0, 1'b0, 32'd0, 32'h0};

    reset      = 1'b0;
    pc_index   = '0;
    pc_valid   = 1'b0;
    mem_ack    = 1'b0;
    mem_rdata  = '0;
    redirect   = 1'b0;
    inst_ready = 1'b0;

    repeat (2) cyc();
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_iv", 32'(inst_valid), 32'd0);
    chk("rst_data", inst_data, 32'h0);
    chk("rst_pc", inst_pc, 32'h0);
    reset = 1'b1;

    // basic fetch at index 5, then redirect coinciding with ack
    for (int i = 0; i < 10; i++) begin
      pc_valid   = tbl[i].pv;
      pc_index   = tbl[i].idx;
      mem_ack    = tbl[i].ack;
      mem_rdata  = tbl[i].rd;
      redirect   = tbl[i].rdr;
      inst_ready = tbl[i].ir;
      #1;
      chk($sformatf("v%0d_pr", i), 32'(pc_ready), 32'(tbl[i].e_pr));
      chk($sformatf("v%0d_req", i), 32'(mem_req), 32'(tbl[i].e_req));
      if (tbl[i].e_req)
        chk($sformatf("v%0d_addr", i), mem_addr, tbl[i].e_addr);
      chk($sformatf("v%0d_iv", i), 32'(inst_valid), 32'(tbl[i].e_iv));
      if (tbl[i].e_iv) begin
        chk($sformatf("v%0d_pc", i), inst_pc, tbl[i].e_pc);
        chk($sformatf("v%0d_data", i), inst_data, tbl[i].e_data);
      end
      cyc();
    end
    pc_valid   = 1'b0;
    mem_ack    = 1'b0;
    redirect   = 1'b0;
    inst_ready = 1'b0;

    // fill queue with decode stalled, then drain in order
    for (int i = 0; i < 4; i++)
      do_fetch(32'(i), 32'h1000 + 32'(i), 1'b0);
    pc_valid = 1'b1;
    pc_index = 32'd4;
    #1;
    chk("full_pr", 32'(pc_ready), 32'd0);
    chk_head("full_head", 32'd0, 32'h1000);
    cyc();
    chk("full_pr2", 32'(pc_ready), 32'd0);
    pc_valid   = 1'b0;
    inst_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk_head($sformatf("drain%0d", i), 32'(i), 32'h1000 + 32'(i));
      cyc();
    end
    chk("drained_iv", 32'(inst_valid), 32'd0);
    do_fetch(32'd4, 32'h1004, 1'b0);
    chk_head("idx4", 32'd4, 32'h1004);
    cyc();
    chk("idx4_pop", 32'(inst_valid), 32'd0);
    inst_ready = 1'b0;

    // redirect during REQ at 0x20, second redirect in DROP
    do_fetch(32'd1, 32'hAAAA0001, 1'b0);
    pc_valid = 1'b1;
    pc_index = 32'd8;
    cyc();
    pc_valid = 1'b0;
    chk("drop_addr", mem_addr, 32'h20);
    chk("drop_req", 32'(mem_req), 32'd1);
    redirect = 1'b1;
    #1;
    chk("rdr_pr", 32'(pc_ready), 32'd0);
    cyc();
    chk("flush_iv", 32'(inst_valid), 32'd0);
    chk("drop_req_hold", 32'(mem_req), 32'd1);
    cyc();
    redirect = 1'b0;
    pc_valid = 1'b1;
    pc_index = 32'd12;
    #1;
    chk("drop_pr", 32'(pc_ready), 32'd0);
    chk("drop_req_hold2", 32'(mem_req), 32'd1);
    mem_ack   = 1'b1;
    mem_rdata = 32'hBAD0BAD0;
    cyc();
    mem_ack  = 1'b0;
    pc_valid = 1'b0;
    #1;
    chk("drop_done_req", 32'(mem_req), 32'd0);
    chk("drop_done_iv", 32'(inst_valid), 32'd0);
    chk("drop_done_pr", 32'(pc_ready), 32'd1);
    do_fetch(32'd12, 32'h0C0C0C0C, 1'b0);
    chk_head("after_drop", 32'd12, 32'h0C0C0C0C);
    inst_ready = 1'b1;
    cyc();
    inst_ready = 1'b0;
    chk("after_drop_pop", 32'(inst_valid), 32'd0);

    // push+pop at the same edge, then full queue across pointer wrap
    do_fetch(32'd20, 32'h20, 1'b0);
    do_fetch(32'd21, 32'h21, 1'b0);
    do_fetch(32'd22, 32'h22, 1'b0);
    do_fetch(32'd23, 32'h23, 1'b1);
    #1;
    chk_head("pp_head", 32'd21, 32'h21);
    chk("pp_pr", 32'(pc_ready), 32'd1);
    do_fetch(32'd24, 32'h24, 1'b0);
    #1;
    chk("wrap_full_pr", 32'(pc_ready), 32'd0);
    inst_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk_head($sformatf("wrap%0d", k), 32'd21 + 32'(k), 32'h21 + 32'(k));
      cyc();
    end
    chk("wrap_empty", 32'(inst_valid), 32'd0);
    inst_ready = 1'b0;

    // reset mid-request (with redirect) then a stray ack
    do_fetch(32'd30, 32'h30, 1'b0);
    pc_valid = 1'b1;
    pc_index = 32'd9;
    cyc();
    pc_valid = 1'b0;
    chk("mid_req", 32'(mem_req), 32'd1);
    chk("mid_addr", mem_addr, 32'h24);
    reset    = 1'b0;
    redirect = 1'b1;
    cyc();
    reset    = 1'b1;
    redirect = 1'b0;
    #1;
    chk("mr_req", 32'(mem_req), 32'd0);
    chk("mr_addr", mem_addr, 32'h0);
    chk("mr_iv", 32'(inst_valid), 32'd0);
    chk("mr_data", inst_data, 32'h0);
    chk("mr_pc", inst_pc, 32'h0);
    chk("mr_pr", 32'(pc_ready), 32'd1);
    mem_ack   = 1'b1;
    mem_rdata = 32'h57575757;
    cyc();
    mem_ack = 1'b0;
    chk("stray_iv", 32'(inst_valid), 32'd0);
    chk("stray_req", 32'(mem_req), 32'd0);
    chk("stray_data", inst_data, 32'h0);
    do_fetch(32'd10, 32'h10, 1'b0);
    chk_head("post_rst", 32'd10, 32'h10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
